nibble_add_seq: RTL and testbench

Multi-cycle sequencer that adds two WIDTH-bit operands using a single 4-bit ripple-carry slice. It processes one nibble per clock, from least significant to most significant, and carries the slice carry-out between cycles in a register. It sits between a requester, using a start/done handshake, and the shared 4-bit adder datapath. It trades latency for area on wide additions.

---
 rtl/nibble_add_seq_pkg.sv | 21 ++
 rtl/nibble_add_seq_if.sv | 26 ++
 rtl/nibble_add_seq_slice.sv | 26 ++
 rtl/nibble_add_seq.sv | 134 +++++++++++++
 tb/tb_nibble_add_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_add_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package nibble_add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nslice_of(input int width);
        return width / SLICE_W;
    endfunction

    // Keeps idx at least one bit wide even for a single-pass build.
    function automatic int idx_w_of(input int width);
        return (nslice_of(width) > 1) ? $clog2(nslice_of(width)) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_seq_if.sv
// Requester-side handshake and operand/result bus for nibble_add_seq.
// The op port exists only when NIBBLE_ADD_SEQ_SUB_EN is defined.
interface nibble_add_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic             op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    modport master (output start, a, b, cin, op, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, op, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/nibble_add_seq_slice.sv
// Combinational 4-bit ripple-carry adder built from a chain of full adders.
module add_slice4
    import nibble_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    logic [SLICE_W:0] c;

    assign c[0] = cin_i;

    genvar i;
    generate
        for (i = 0; i < SLICE_W; i++) begin : g_fa
            assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    endgenerate

    assign cout_o = c[SLICE_W];

endmodule

// File: rtl/nibble_add_seq.sv
// WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock, LSB first.
// Define NIBBLE_ADD_SEQ_SUB_EN to add the op input (1 = subtract a-b).
module nibble_add_seq
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    nibble_add_seq_if.slave bus
);

    localparam int NSLICE = nslice_of(WIDTH);
    localparam int IW     = idx_w_of(WIDTH);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_add_seq: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IW-1:0]    idx_q, idx_d;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic             op_q, op_d;
`endif

    logic [IW+1:0]      bit_off;
    logic [SLICE_W-1:0] s_a, s_b, s_sum;
    logic               s_cout;

    // Bit offset of the current nibble; idx * 4 as a plain concatenation.
    assign bit_off = {idx_q, 2'b00};
    assign s_a     = a_q[bit_off +: SLICE_W];
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    assign s_b     = b_q[bit_off +: SLICE_W] ^ {SLICE_W{op_q}};
`else
    assign s_b     = b_q[bit_off +: SLICE_W];
`endif

    add_slice4 u_slice (
        .a_i    (s_a),
        .b_i    (s_b),
        .cin_i  (carry_q),
        .sum_o  (s_sum),
        .cout_o (s_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        op_d    = op_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    idx_d   = '0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
                    op_d    = bus.op;
                    // Two's complement subtract: inverted b plus an initial carry.
                    carry_d = bus.op ? 1'b1 : bus.cin;
`else
                    carry_d = bus.cin;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d[bit_off +: SLICE_W] = s_sum;
                carry_d                   = s_cout;
                if (idx_q == IW'(NSLICE - 1)) begin
                    state_d = DONE;
                    sum_d   = acc_d;
                    cout_d  = s_cout;
                end else begin
                    idx_d   = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            op_q    <= op_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed plus random checks of nibble_add_seq against a plain-arithmetic model.
module tb_nibble_add_seq;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   npass  = 0;
    int   ntotal = 0;

    nibble_add_seq_if #(.WIDTH(W)) bus ();

    nibble_add_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // {cout, sum} straight from the arithmetic definition.
    function automatic logic [W:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic sub);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = c;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        bus.op    = sub;
`else
        if (sub) $display("note: subtract requested without NIBBLE_ADD_SEQ_SUB_EN");
`endif
    endtask

    // One operation; inj >= 0 pulses a stray start during that RUN cycle index.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic sub, input int inj);
        logic [W-1:0] psum;
        logic         pcout;
        logic [W:0]   exp;
        int           n, bcnt;
        bit           held;
        psum  = bus.sum;
        pcout = bus.cout;
        exp   = ref_res(a, b, c, sub);
        @(negedge clk);
        drive(a, b, c, sub);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bcnt = bus.busy ? 1 : 0;
        n    = 0;
        held = 1'b1;
        while (!bus.done && n < 20) begin
            if (bus.sum !== psum || bus.cout !== pcout) held = 1'b0;
            @(negedge clk);
            if (n == inj) begin
                bus.start = 1'b1;
                bus.a     = 16'hAAAA;
                bus.b     = 16'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (bus.busy) bcnt++;
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd4);
        chk({tag, "_held_during_run"}, 32'(held), 32'd1);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(exp[W-1:0]));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(exp[W]));
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] xa[5];
        logic [W-1:0] xb[5];
        logic         xc[5];
        logic [W:0]   exp;
        logic [W-1:0] psum;
        logic         pcout;
        bit           ok;
        int           e;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        bus.op    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, -1);
        run_op("carry_out", 16'hFFFF, 16'h0001, 1'b0, 1'b0, -1);
        run_op("ripple_all", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, -1);
        run_op("start_ignored", 16'h00F0, 16'h0010, 1'b0, 1'b0, 1);

        // Back-to-back: start held high, fresh operands presented for each DONE.
        for (int i = 0; i < 5; i++) begin
            xa[i] = 16'($urandom);
            xb[i] = 16'($urandom);
            xc[i] = 1'($urandom);
        end
        @(negedge clk);
        drive(xa[0], xb[0], xc[0], 1'b0);
        @(posedge clk); #1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j < 4) drive(xa[j+1], xb[j+1], xc[j+1], 1'b0);
            else bus.start = 1'b0;
            e = 0;
            while (!bus.done && e < 20) begin
                @(posedge clk); #1;
                e++;
            end
            exp = ref_res(xa[j], xb[j], xc[j], 1'b0);
            chk("b2b_latency", 32'(e), 32'd4);
            chk("b2b_sum", 32'(bus.sum), 32'(exp[W-1:0]));
            chk("b2b_cout", 32'(bus.cout), 32'(exp[W]));
            @(posedge clk); #1;
            chk("b2b_no_dup_done", 32'(bus.done), 32'd0);
            chk("b2b_restart", 32'(bus.busy), (j < 4) ? 32'd1 : 32'd0);
        end

        // Result registers must hold across a long idle stretch.
        psum  = bus.sum;
        pcout = bus.cout;
        ok    = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.sum !== psum || bus.cout !== pcout || bus.done !== 1'b0) ok = 1'b0;
        end
        chk("idle_hold", 32'(ok), 32'd1);

        // Reset two nibbles into RUN, with a competing start that must lose.
        @(negedge clk);
        drive(16'h7777, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_sum", 32'(bus.sum), 32'd0);
        chk("midrst_cout", 32'(bus.cout), 32'd0);
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
        end
        chk("midrst_no_done", 32'(ok), 32'd1);
        run_op("after_rst", 16'h8001, 16'h7FFF, 1'b1, 1'b0, -1);

`ifdef NIBBLE_ADD_SEQ_SUB_EN
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, -1);
        run_op("sub_noborrow", 16'h1000, 16'h0001, 1'b1, 1'b1, -1);
`endif

        for (int r = 0; r < 16; r++) begin
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), -1);
`else
            run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, -1);
`endif
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
